// File: rtl/mdu_sequencer.sv
// Iterative RV64M multiply/divide sequencer: shift-add multiply and restoring
// divide, one bit per cycle, stalling the pipeline until the result is ready.
module mdu_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_W      = 7
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_start,
  input  logic [2:0]            i_func3,
  input  logic                  i_word,
  input  logic [DATA_WIDTH-1:0] i_src_1,
  input  logic [DATA_WIDTH-1:0] i_src_2,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int W  = DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       func3_q, func3_d;
  logic             word_q, word_d;
  logic [W-1:0]     srcA_q, srcA_d, srcB_q, srcB_d;
  logic [W-1:0]     opB_q, opB_d;
  logic [W-1:0]     result_q, result_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negRes_q, negRes_d, remNeg_q, remNeg_d;

  logic             isDiv, isRem, divSigned, aSigned, bSigned, aNeg, bNeg;
  logic             divZero, divOvf, mulLow;
  logic [W-1:0]     extA, extB, magA, magB, minVal, divLoad;
  logic [W-1:0]     specRaw, specRes, fixRaw, fixRes;
  logic [W:0]       mulSum, divShift;
  logic [W-1:0]     divRem;
  logic             divGe;
  logic [2*W-1:0]   mulNext, divNext, prodRaw, prodSigned;
  logic [W-1:0]     quoSigned, remSigned;

  // Operand decode from the latched op; mulw is handled as an unsigned 32x32.
  always_comb begin
    isDiv     = func3_q[2];
    isRem     = func3_q[2] & func3_q[1];
    divSigned = func3_q[2] & ~func3_q[0];
    aSigned   = isDiv ? divSigned : (~word_q & ((func3_q == 3'd1) | (func3_q == 3'd2)));
    bSigned   = isDiv ? divSigned : (~word_q & (func3_q == 3'd1));
    mulLow    = (func3_q == 3'd0) | word_q;

    if (word_q && divSigned) begin
      extA = {{HW{srcA_q[HW-1]}}, srcA_q[HW-1:0]};
      extB = {{HW{srcB_q[HW-1]}}, srcB_q[HW-1:0]};
    end else if (word_q) begin
      extA = {{HW{1'b0}}, srcA_q[HW-1:0]};
      extB = {{HW{1'b0}}, srcB_q[HW-1:0]};
    end else begin
      extA = srcA_q;
      extB = srcB_q;
    end

    aNeg    = aSigned & extA[W-1];
    bNeg    = bSigned & extB[W-1];
    magA    = aNeg ? -extA : extA;
    magB    = bNeg ? -extB : extB;
    divLoad = word_q ? (magA << HW) : magA;

    minVal  = word_q ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
    divZero = isDiv & (extB == '0);
    divOvf  = divSigned & (extA == minVal) & (&extB);

    if (divZero) specRaw = isRem ? extA : {W{1'b1}};
    else         specRaw = isRem ? '0 : extA;
    specRes = word_q ? {{HW{specRaw[HW-1]}}, specRaw[HW-1:0]} : specRaw;
  end

  // One iteration of each datapath; the counter picks which one is committed.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opB_q};
    mulNext  = acc_q[0] ? {mulSum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

    divShift = {acc_q[2*W-1:W], acc_q[W-1]};
    divGe    = divShift >= {1'b0, opB_q};
    divRem   = divShift[W-1:0] - opB_q;
    divNext  = divGe ? {divRem, acc_q[W-2:0], 1'b1}
                     : {divShift[W-1:0], acc_q[W-2:0], 1'b0};

    prodRaw    = word_q ? {{W{1'b0}}, acc_q[W+HW-1:HW]} : acc_q;
    prodSigned = negRes_q ? -prodRaw : prodRaw;
    quoSigned  = negRes_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    remSigned  = remNeg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    if (isDiv)       fixRaw = isRem ? remSigned : quoSigned;
    else if (mulLow) fixRaw = prodSigned[W-1:0];
    else             fixRaw = prodSigned[2*W-1:W];
    fixRes = word_q ? {{HW{fixRaw[HW-1]}}, fixRaw[HW-1:0]} : fixRaw;
  end

  always_comb begin
    state_d  = state_q;
    func3_d  = func3_q;
    word_d   = word_q;
    srcA_d   = srcA_q;
    srcB_d   = srcB_q;
    opB_d    = opB_q;
    result_d = result_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    negRes_d = negRes_q;
    remNeg_d = remNeg_q;

    unique case (state_q)
      IDLE: begin
        if (i_start && !i_flush) begin
          func3_d = i_func3;
          word_d  = i_word;
          srcA_d  = i_src_1;
          srcB_d  = i_src_2;
          state_d = PREP;
        end
      end
      PREP: begin
        cnt_d    = word_q ? CNT_W'(HW) : CNT_W'(W);
        negRes_d = aNeg ^ bNeg;
        remNeg_d = aNeg;
        opB_d    = magB;
        acc_d    = {{W{1'b0}}, isDiv ? divLoad : magA};
        if (divZero || divOvf) begin
          result_d = specRes;
          state_d  = DONE;
        end else begin
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d = isDiv ? divNext : mulNext;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        result_d = fixRes;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A redirect kills the op without disturbing the last delivered result.
    if (i_flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q  <= IDLE;
      func3_q  <= '0;
      word_q   <= 1'b0;
      srcA_q   <= '0;
      srcB_q   <= '0;
      opB_q    <= '0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      negRes_q <= 1'b0;
      remNeg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      func3_q  <= func3_d;
      word_q   <= word_d;
      srcA_q   <= srcA_d;
      srcB_q   <= srcB_d;
      opB_q    <= opB_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      negRes_q <= negRes_d;
      remNeg_q <= remNeg_d;
    end
  end

  assign o_stall  = ((state_q == IDLE) & i_start & ~i_flush) |
                    (state_q == PREP) | (state_q == CALC) | (state_q == FIX);
  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign o_result = result_q;

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide sequencer for the RV64M extension, attached beside the execute-stage ALU. It accepts one M-extension operation from the execute stage and runs it on an internal iterative datapath: shift-add multiply and restoring divide, one bit per cycle. While the operation runs it holds the pipeline stalled, then returns a single 64-bit result for the execute pipeline register to capture.

## Interface
Parameters:
- DATA_WIDTH, 64, operand/result width; fixed at 64 for RV64.
- CNT_W, 7, iteration-counter width; must satisfy 2^CNT_W > DATA_WIDTH.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_arst  in  1  reset, synchronous, active-high.
- i_start  in  1  execute stage holds a valid M-extension op this cycle.
- i_func3  in  3  op select: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- i_word  in  1  W-variant: mulw, divw, divuw, remw, remuw.
- i_src_1  in  DATA_WIDTH  rs1 operand, already forwarded.
- i_src_2  in  DATA_WIDTH  rs2 operand, already forwarded.
- i_flush  in  1  kill the in-flight op (branch/jump redirect).
- o_stall  out  1  freeze fetch/decode/execute registers.
- o_busy  out  1  sequencer not in IDLE.
- o_done  out  1  one-cycle pulse; o_result is valid this cycle.
- o_result  out  DATA_WIDTH  final result.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - On i_start & ~i_flush, latch func3, word, and both operands, then go to PREP.
  - All other inputs are ignored.
- PREP:
  - Word ops: take the low 32 bits of each operand. Sign-extend them for signed ops; zero-extend them for divuw/remuw.
  - Record the operand signs. Convert signed operands to magnitudes (mulhsu: rs1 signed, rs2 unsigned).
  - Load the iteration counter with N: 64, or 32 when i_word.
  - Special cases go straight to DONE with the final result already loaded:
    - divide by zero: quotient = all ones, remainder = dividend.
    - signed overflow (most-negative / -1, at the 32- or 64-bit width in use): quotient = dividend, remainder = 0.
  - All other ops go to CALC.
- CALC:
  - Multiply: each cycle, conditionally add the multiplicand to a 2N-bit product, then shift right one bit.
  - Divide: each cycle, shift the remainder/quotient register left one bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
  - The counter decrements every cycle. Leave for FIX on the cycle the counter reaches 1.
- FIX:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ (signed div).
  - Give the remainder the dividend's sign (signed rem).
  - Select the result:
    - mul/mulw: low half.
    - mulh/mulhsu/mulhu: high half.
    - div(u): quotient.
    - rem(u): remainder.
  - Word ops: sign-extend bit 31 of the result to 64 bits, including divuw/remuw.
  - Go to DONE.
- DONE:
  - o_done = 1 for this cycle, then return to IDLE.
  - o_result is updated at the FIX→DONE (or PREP→DONE) edge and held until the next such edge.
- When i_word = 1, any func3 in 1–3 executes as mulw.
- Flush:
  - i_flush in any state forces IDLE on the next edge with no o_done.
  - o_result keeps its old value.
  - i_flush takes priority over i_start.
- Reset: i_arst in any state, including mid-CALC, aborts the op on the next edge.
  - State becomes IDLE; o_result, o_done, o_busy and the counter become 0; o_stall becomes 0 unless i_start is high.
- Outputs:
  - o_stall = (IDLE & i_start & ~i_flush) | (state ∈ {PREP, CALC, FIX}). It is combinational, so the stall takes effect in the same cycle the op appears.
  - o_stall = 0 in DONE, so the pipeline advances with o_result on that cycle.
  - o_busy = (state ≠ IDLE).

## Timing
- Call the cycle in which i_start is sampled in IDLE cycle 0.
- Normal op: PREP in cycle 1, CALC in cycles 2..N+1, FIX in cycle N+2, DONE (o_done = 1) in cycle N+3.
  - 64-bit ops: o_done in cycle 67. Word ops: o_done in cycle 35.
- Special case (div-by-zero or overflow): DONE in cycle 2.
- o_stall is high from cycle 0 through the cycle before DONE.
- Back-to-back ops: the earliest next start is sampled the cycle after DONE (IDLE). A new op can never be accepted in DONE.
- Throughput: at most one op per N+4 cycles (one per 3 cycles for special cases).

## Test plan
- mul 7 × -3 (64-bit): o_done in cycle 67, o_result = 0xFFFF_FFFF_FFFF_FFEB. Also check o_stall is high in cycles 0–66 and low in cycle 67.
- mulhu 0xFFFF_FFFF_FFFF_FFFF × 2 → o_result = 1. mulh -1 × -1 → o_result = 0.
- divw with i_src_1 = 0x0000_0000_8000_0000 (-2^31) and i_src_2 = -1:
  - o_done in cycle 2, o_result = 0xFFFF_FFFF_8000_0000.
  - remw with the same operands → 0.
- divu 100 / 0 → o_result = 0xFFFF_FFFF_FFFF_FFFF in cycle 2. remu 100 / 0 → o_result = 100.
- rem -7 / 2 → o_result = -1. div -7 / 2 → o_result = -3. Check back-to-back: the second i_start, held from cycle 68, produces o_done in cycle 135.
- Abort paths:
  - Start div, assert i_flush in cycle 20: state IDLE in cycle 21, no o_done, o_result unchanged.
  - Repeat with i_arst in cycle 20: all outputs 0 in cycle 21.
